food_spawner: RTL and testbench

- Parametrised successor to the random food-box generator in the LED-array snake game.
- On a spawn request, draws pseudo-random grid coordinates from an internal 16-bit LFSR and rejects any that fall outside the grid.
- Checks each in-range candidate against the snake body through an external occupancy-query handshake. After MAX_TRIES failed draws it falls back to a deterministic linear scan, and reports "grid full" if no free cell exists.
- Sits between the game-control FSM (spawn/box_vld) and the snake-body store (chk_* query port); feeds box_x/box_y to the display renderer.

---
 rtl/food_spawner_if.sv | 37 +++
 rtl/food_spawner.sv | 264 ++++++++++++++++++++++++++
 tb/tb_food_spawner.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/food_spawner_if.sv
// -----------------------------------------------------------------------------
// food_spawner_if
//   Occupancy-query handshake between the food spawner and the snake-body
//   store. The spawner asks "is (chk_x, chk_y) part of the snake?" and
//   the store answers some cycles later.
//
//   chk_req  spawner -> store  one-cycle query pulse
//   chk_x    spawner -> store  queried column, held until the answer
//   chk_y    spawner -> store  queried row, held until the answer
//   chk_vld  store -> spawner  answer valid (one or more cycles after chk_req)
//   chk_occ  store -> spawner  1 = queried cell is occupied, qualified by chk_vld
//
//   modport master : the spawner side
//   modport slave  : the snake-body store side
// -----------------------------------------------------------------------------
interface food_spawner_if #(
  parameter int X_W = 7,
  parameter int Y_W = 5
);

  logic           chk_req;
  logic [X_W-1:0] chk_x;
  logic [Y_W-1:0] chk_y;
  logic           chk_vld;
  logic           chk_occ;

  modport master (
    output chk_req, chk_x, chk_y,
    input  chk_vld, chk_occ
  );

  modport slave (
    input  chk_req, chk_x, chk_y,
    output chk_vld, chk_occ
  );

endinterface

// File: rtl/food_spawner.sv
// -----------------------------------------------------------------------------
// food_spawner
//   Places the next food box for the LED-array snake game. On a spawn request
//   it draws random cells from a 16-bit LFSR, discards those outside the grid,
//   and asks the snake-body store whether each in-range candidate is free.
//   After MAX_TRIES draws without a free cell it scans the grid linearly from
//   a deterministic origin. If the whole grid turns out to be occupied, it
//   reports "full" instead of moving the box.
//
//   clk        system clock
//   rst        synchronous reset, active-high
//   spawn_i    request a new box (only honoured while idle)
//   busy_o     high from spawn acceptance until box_vld_o or full_o
//   box_x_o    current box column, held between spawns
//   box_y_o    current box row
//   box_vld_o  one-cycle pulse when box_x_o/box_y_o update
//   full_o     one-cycle pulse when no free cell exists
//   chk        occupancy-query handshake (master side)
// -----------------------------------------------------------------------------
module food_spawner #(
  parameter int          X_W       = 7,
  parameter int          Y_W       = 5,
  parameter int          GRID_W    = 96,
  parameter int          GRID_H    = 32,
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          INIT_X    = 10,
  parameter int          INIT_Y    = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           spawn_i,
  output logic           busy_o,
  output logic [X_W-1:0] box_x_o,
  output logic [Y_W-1:0] box_y_o,
  output logic           box_vld_o,
  output logic           full_o,
  food_spawner_if.master chk
);

  typedef enum logic [2:0] {
    IDLE,    // waiting for spawn
    DRAW,    // one random draw per cycle
    WAIT_R,  // waiting for the answer to a random-phase query
    SCAN,    // issue the query for the current scan cell
    WAIT_S   // waiting for the answer to a scan query
  } state_e;

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [15:0]    LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int             X_LAST_I  = GRID_W - 1;
  localparam int             Y_LAST_I  = GRID_H - 1;
  localparam int             CELLS_I   = GRID_W * GRID_H;
  localparam logic [X_W:0]   X_LIM     = GRID_W[X_W:0];
  localparam logic [Y_W:0]   Y_LIM     = GRID_H[Y_W:0];
  localparam logic [X_W-1:0] X_LAST    = X_LAST_I[X_W-1:0];
  localparam logic [Y_W-1:0] Y_LAST    = Y_LAST_I[Y_W-1:0];
  localparam logic [X_W-1:0] X_INIT    = INIT_X[X_W-1:0];
  localparam logic [Y_W-1:0] Y_INIT    = INIT_Y[Y_W-1:0];
  localparam logic [7:0]     TRIES     = MAX_TRIES[7:0];
  localparam logic [16:0]    CELLS     = CELLS_I[16:0];

  state_e         state_q,    state_d;
  logic [15:0]    lfsr_q,     lfsr_d;
  logic [7:0]     try_cnt_q,  try_cnt_d;
  logic [15:0]    scan_cnt_q, scan_cnt_d;
  logic [X_W-1:0] box_x_q,    box_x_d;
  logic [Y_W-1:0] box_y_q,    box_y_d;
  logic           box_vld_q,  box_vld_d;
  logic           full_q,     full_d;
  logic           busy_q,     busy_d;
  logic           chk_req_q,  chk_req_d;
  // chk_x_q/chk_y_q double as the scan cursor: during the scan the last
  // queried cell is always the one to advance from.
  logic [X_W-1:0] chk_x_q,    chk_x_d;
  logic [Y_W-1:0] chk_y_q,    chk_y_d;

  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           cand_ok;
  logic [7:0]     try_inc;
  logic           last_try;
  logic           more_tries;
  logic           more_cells;
  logic           ans;
  logic           x_wrap;
  logic           y_wrap;
  logic [X_W-1:0] nxt_x;
  logic [Y_W-1:0] nxt_y;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  // Fibonacci LFSR, taps 16,14,13,11; free-running in every state.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign cand_x  = lfsr_q[X_W-1:0];
  assign cand_y  = lfsr_q[X_W+Y_W-1:X_W];
  assign cand_ok = ({1'b0, cand_x} < X_LIM) && ({1'b0, cand_y} < Y_LIM);

  // try_cnt counts draws already made; the draw in progress is try_inc.
  assign try_inc    = try_cnt_q + 8'd1;
  assign last_try   = (try_inc == TRIES);
  assign more_tries = (try_cnt_q < TRIES);
  assign more_cells = ({1'b0, scan_cnt_q} < CELLS);

  // An answer arriving while chk_req is still high belongs to no query yet.
  assign ans = chk.chk_vld && !chk_req_q;

  // Raster order: x first, then y, wrapping at the grid edge.
  assign x_wrap = (chk_x_q == X_LAST);
  assign y_wrap = (chk_y_q == Y_LAST);
  assign nxt_x  = x_wrap ? '0 : chk_x_q + 1'b1;
  assign nxt_y  = x_wrap ? (y_wrap ? '0 : chk_y_q + 1'b1) : chk_y_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_INIT;
      try_cnt_q  <= '0;
      scan_cnt_q <= '0;
      box_x_q    <= X_INIT;
      box_y_q    <= Y_INIT;
      box_vld_q  <= 1'b0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      chk_req_q  <= 1'b0;
      chk_x_q    <= '0;
      chk_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      try_cnt_q  <= try_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      box_x_q    <= box_x_d;
      box_y_q    <= box_y_d;
      box_vld_q  <= box_vld_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      chk_req_q  <= chk_req_d;
      chk_x_q    <= chk_x_d;
      chk_y_q    <= chk_y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (spawn_i) state_d = DRAW;
      DRAW: begin
        if (cand_ok)       state_d = WAIT_R;
        else if (last_try) state_d = SCAN;
      end
      WAIT_R: begin
        if (ans) begin
          if (!chk.chk_occ)    state_d = IDLE;
          else if (more_tries) state_d = DRAW;
          else                 state_d = SCAN;
        end
      end
      SCAN:   state_d = WAIT_S;
      WAIT_S: begin
        if (ans) begin
          if (!chk.chk_occ)    state_d = IDLE;
          else if (more_cells) state_d = SCAN;
          else                 state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    try_cnt_d  = try_cnt_q;
    scan_cnt_d = scan_cnt_q;
    box_x_d    = box_x_q;
    box_y_d    = box_y_q;
    box_vld_d  = 1'b0;
    full_d     = 1'b0;
    busy_d     = busy_q;
    chk_req_d  = 1'b0;
    chk_x_d    = chk_x_q;
    chk_y_d    = chk_y_q;

    unique case (state_q)
      IDLE: begin
        if (spawn_i) begin
          busy_d    = 1'b1;
          try_cnt_d = '0;
        end
      end
      DRAW: begin
        try_cnt_d = try_inc;
        if (cand_ok) begin
          chk_req_d = 1'b1;
          chk_x_d   = cand_x;
          chk_y_d   = cand_y;
        end else if (last_try) begin
          chk_x_d    = '0;
          chk_y_d    = '0;
          scan_cnt_d = '0;
        end
      end
      WAIT_R: begin
        if (ans) begin
          if (!chk.chk_occ) begin
            box_x_d   = chk_x_q;
            box_y_d   = chk_y_q;
            box_vld_d = 1'b1;
            busy_d    = 1'b0;
          end else if (!more_tries) begin
            chk_x_d    = nxt_x;
            chk_y_d    = nxt_y;
            scan_cnt_d = '0;
          end
        end
      end
      SCAN: begin
        chk_req_d  = 1'b1;
        scan_cnt_d = scan_cnt_q + 16'd1;
      end
      WAIT_S: begin
        if (ans) begin
          if (!chk.chk_occ) begin
            box_x_d   = chk_x_q;
            box_y_d   = chk_y_q;
            box_vld_d = 1'b1;
            busy_d    = 1'b0;
          end else if (more_cells) begin
            chk_x_d = nxt_x;
            chk_y_d = nxt_y;
          end else begin
            full_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy_o      = busy_q;
  assign box_x_o     = box_x_q;
  assign box_y_o     = box_y_q;
  assign box_vld_o   = box_vld_q;
  assign full_o      = full_q;
  assign chk.chk_req = chk_req_q;
  assign chk.chk_x   = chk_x_q;
  assign chk.chk_y   = chk_y_q;

endmodule

// File: tb/tb_food_spawner.sv
// -----------------------------------------------------------------------------
// tb_food_spawner
//   Two spawners share clock and reset: u_big on the default 96x32 grid and
//   u_small on a 5x3 grid. The bench plays the snake-body store and predicts
//   every query, box and full pulse from the game rules: the LFSR sequence,
//   the range test, the try budget and the raster scan order.
// -----------------------------------------------------------------------------
module tb_food_spawner;

  localparam int X_W       = 7;
  localparam int Y_W       = 5;
  localparam int MAX_TRIES = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           spawn  [2];
  logic           vld    [2];
  logic           occ_in [2];
  logic           busy   [2];
  logic           bvld   [2];
  logic           full   [2];
  logic [X_W-1:0] bx     [2];
  logic [Y_W-1:0] by     [2];
  logic           req    [2];
  logic [X_W-1:0] qx     [2];
  logic [Y_W-1:0] qy     [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_x [2];
  int          exp_y [2];
  int          free_x, free_y;
  logic [31:0] occ_mask;
  logic [15:0] m_lfsr;

  food_spawner_if #(.X_W(X_W), .Y_W(Y_W)) bus0 ();
  food_spawner_if #(.X_W(X_W), .Y_W(Y_W)) bus1 ();

  assign bus0.chk_vld = vld[0];
  assign bus0.chk_occ = occ_in[0];
  assign bus1.chk_vld = vld[1];
  assign bus1.chk_occ = occ_in[1];
  assign req[0] = bus0.chk_req;
  assign qx[0]  = bus0.chk_x;
  assign qy[0]  = bus0.chk_y;
  assign req[1] = bus1.chk_req;
  assign qx[1]  = bus1.chk_x;
  assign qy[1]  = bus1.chk_y;

  food_spawner #(
    .X_W(X_W), .Y_W(Y_W), .GRID_W(96), .GRID_H(32), .MAX_TRIES(MAX_TRIES),
    .SEED(16'hACE1), .INIT_X(10), .INIT_Y(5)
  ) u_big (
    .clk(clk), .rst(rst), .spawn_i(spawn[0]), .busy_o(busy[0]),
    .box_x_o(bx[0]), .box_y_o(by[0]), .box_vld_o(bvld[0]), .full_o(full[0]),
    .chk(bus0)
  );

  food_spawner #(
    .X_W(X_W), .Y_W(Y_W), .GRID_W(5), .GRID_H(3), .MAX_TRIES(MAX_TRIES),
    .SEED(16'hACE1), .INIT_X(10), .INIT_Y(5)
  ) u_small (
    .clk(clk), .rst(rst), .spawn_i(spawn[1]), .busy_o(busy[1]),
    .box_x_o(bx[1]), .box_y_o(by[1]), .box_vld_o(bvld[1]), .full_o(full[1]),
    .chk(bus1)
  );

  function automatic int gw(input int s);
    return (s == 0) ? 96 : 5;
  endfunction

  function automatic int gh(input int s);
    return (s == 0) ? 32 : 3;
  endfunction

  // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, one step per clock.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  // Snake-body occupancy: 0 all free, 1 only (free_x,free_y) free,
  // 2 all occupied, otherwise one bit of occ_mask per cell.
  function automatic bit occupied(input int s, input int mode, input int x, input int y);
    case (mode)
      0:       return 1'b0;
      1:       return !(x == free_x && y == free_y);
      2:       return 1'b1;
      default: return occ_mask[(y * gw(s) + x) % 32];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every query on either spawner must name an in-range cell.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (req[s] === 1'b1) begin
        check("range_x", 32'(int'(qx[s]) < gw(s)), 1);
        check("range_y", 32'(int'(qy[s]) < gh(s)), 1);
      end
    end
  end

  task automatic next_cell(input int s, inout int x, inout int y);
    if (x == gw(s) - 1) begin
      x = 0;
      y = (y == gh(s) - 1) ? 0 : y + 1;
    end else begin
      x++;
    end
  endtask

  // Called at the negedge where chk_req is seen; answers after 1..3 cycles.
  // early: drive a bogus free answer in the chk_req cycle itself.
  // poke:  pulse spawn while the spawner is busy.
  task automatic answer(input int s, input int x, input int y, input int mode,
                        input bit early, input bit poke, output bit occ);
    int lat;
    occ = occupied(s, mode, x, y);
    lat = $urandom_range(1, 3);
    if (early) begin
      vld[s]    = 1'b1;
      occ_in[s] = 1'b0;
    end
    for (int i = 0; i < lat; i++) begin
      if (poke && i == 0) spawn[s] = 1'b1;
      @(negedge clk);
      spawn[s]  = 1'b0;
      vld[s]    = 1'b0;
      occ_in[s] = 1'b0;
      check("wait_req",  req[s],  0);
      check("wait_vld",  bvld[s], 0);
      check("wait_busy", busy[s], 1);
      check("hold_x",    qx[s],   x);
      check("hold_y",    qy[s],   y);
    end
    vld[s]    = 1'b1;
    occ_in[s] = occ;
    @(negedge clk);
    vld[s]    = 1'b0;
    occ_in[s] = 1'b0;
  endtask

  task automatic expect_commit(input int s, input int x, input int y);
    check("box_vld",   bvld[s], 1);
    check("box_x",     bx[s],   x);
    check("box_y",     by[s],   y);
    check("busy_drop", busy[s], 0);
    check("no_full",   full[s], 0);
    exp_x[s] = x;
    exp_y[s] = y;
  endtask

  task automatic idle_check(input int s);
    @(negedge clk);
    check("idle_busy", busy[s], 0);
    check("idle_vld",  bvld[s], 0);
    check("idle_full", full[s], 0);
    check("idle_req",  req[s],  0);
    check("idle_x",    bx[s],   exp_x[s]);
    check("idle_y",    by[s],   exp_y[s]);
  endtask

  // One complete spawn on instance s, entered and left at a negedge.
  // abort_at > 0 asserts rst while the abort_at-th scan query is pending.
  task automatic spawn_run(input int s, input int mode, input bit early,
                           input bit poke, input int abort_at);
    int          tries, cx, cy, sx, sy, cells;
    bit          occ, scanning;
    logic [15:0] cand;
    tries    = 0;
    scanning = 1'b0;
    sx       = 0;
    sy       = 0;
    spawn[s] = 1'b1;
    @(negedge clk);
    spawn[s] = 1'b0;
    check("busy_rise", busy[s], 1);

    // Random phase: each draw uses the LFSR value of the cycle before it.
    while (!scanning) begin
      cand = m_lfsr;
      cx   = int'(cand[X_W-1:0]);
      cy   = int'(cand[X_W+Y_W-1:X_W]);
      @(negedge clk);
      tries++;
      if (cx < gw(s) && cy < gh(s)) begin
        check("draw_req", req[s], 1);
        check("draw_x",   qx[s],  cx);
        check("draw_y",   qy[s],  cy);
        answer(s, cx, cy, mode, early, poke, occ);
        early = 1'b0;
        poke  = 1'b0;
        if (!occ) begin
          expect_commit(s, cx, cy);
          return;
        end
        check("draw_miss_vld", bvld[s], 0);
        if (tries == MAX_TRIES) begin
          sx = cx;
          sy = cy;
          next_cell(s, sx, sy);
          scanning = 1'b1;
        end
      end else begin
        check("draw_reject", req[s], 0);
        if (tries == MAX_TRIES) scanning = 1'b1;
      end
    end

    // Linear scan phase.
    cells = gw(s) * gh(s);
    for (int n = 1; n <= cells; n++) begin
      @(negedge clk);
      check("scan_req", req[s], 1);
      check("scan_x",   qx[s],  sx);
      check("scan_y",   qy[s],  sy);
      if (n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy[s], 0);
        check("abort_vld",  bvld[s], 0);
        check("abort_full", full[s], 0);
        check("abort_req",  req[s],  0);
        check("abort_x",    bx[s],   10);
        check("abort_y",    by[s],   5);
        exp_x = '{10, 10};
        exp_y = '{5, 5};
        return;
      end
      answer(s, sx, sy, mode, early, poke, occ);
      early = 1'b0;
      poke  = 1'b0;
      if (!occ) begin
        expect_commit(s, sx, sy);
        return;
      end
      if (n == cells) begin
        check("full_pulse", full[s], 1);
        check("full_vld",   bvld[s], 0);
        check("full_busy",  busy[s], 0);
        check("full_x",     bx[s],   exp_x[s]);
        check("full_y",     by[s],   exp_y[s]);
        return;
      end
      check("scan_miss_vld",  bvld[s], 0);
      check("scan_miss_full", full[s], 0);
      next_cell(s, sx, sy);
    end
  endtask

  initial begin
    rst      = 1'b1;
    spawn    = '{1'b0, 1'b0};
    vld      = '{1'b0, 1'b0};
    occ_in   = '{1'b0, 1'b0};
    exp_x    = '{10, 10};
    exp_y    = '{5, 5};
    free_x   = 0;
    free_y   = 0;
    occ_mask = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_box_x", bx[s],   10);
      check("rst_box_y", by[s],   5);
      check("rst_busy",  busy[s], 0);
      check("rst_vld",   bvld[s], 0);
      check("rst_full",  full[s], 0);
      check("rst_req",   req[s],  0);
      check("rst_chk_x", qx[s],   0);
      check("rst_chk_y", qy[s],   0);
    end
    check("rst_lfsr_big",   u_big.lfsr_q,   16'hACE1);
    check("rst_lfsr_small", u_small.lfsr_q, 16'hACE1);
    rst = 1'b0;

    // Stray answers while idle change nothing.
    vld[0]    = 1'b1;
    occ_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    vld[0] = 1'b0;
    idle_check(0);

    // Free board: first in-range draw wins; first run also sends an early
    // answer, second one pulses spawn while busy.
    for (int i = 0; i < 6; i++) begin
      spawn_run(0, 0, i == 0, i == 1, 0);
      idle_check(0);
    end

    // Only the last cell free: random draws all miss, scan reaches it.
    free_x = 95;
    free_y = 31;
    spawn_run(0, 1, 1'b0, 1'b1, 0);
    idle_check(0);
    check("fallback_x_95", bx[0], 95);
    check("fallback_y_31", by[0], 5'd31);

    // Only the origin free: the scan has to wrap past the last cell.
    free_x = 0;
    free_y = 0;
    spawn_run(0, 1, 1'b0, 1'b0, 0);
    idle_check(0);
    check("fallback_x_0", bx[0], 0);
    check("fallback_y_0", by[0], 0);

    // Small grid, fully occupied: full pulse, box untouched.
    spawn_run(1, 2, 1'b0, 1'b0, 0);
    idle_check(1);
    check("full_keep_x", bx[1], 10);
    check("full_keep_y", by[1], 5);

    // Small grid, random occupancy and random handshake disturbances.
    for (int i = 0; i < 200; i++) begin
      occ_mask = $urandom;
      spawn_run(1, 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      idle_check(1);
    end

    // Reset while a scan query is outstanding.
    spawn_run(1, 2, 1'b0, 1'b0, 3);
    repeat (3) begin
      idle_check(1);
      idle_check(0);
    end

    // Spawning after the abort follows the restarted LFSR sequence.
    spawn_run(0, 0, 1'b0, 1'b0, 0);
    idle_check(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
